// File: rtl/qam_pkg.sv
// ============================================================================
//  Module      : qam_pkg
//  Description : Shared types and constants for the QAM symbol mapper.
//                Holds the FSM state encoding, the Gray-coded amplitude level
//                table, the QPSK level multiplier and the symbol counter
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qam_pkg;

    // Mapper control states; explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Symbol counter width.
    localparam int c_SYM_CNT_W = 16;

    // QPSK symbols sit at +/-2 amplitude units.
    localparam int c_QPSK_MULT = 2;

    // Gray-coded level multiplier for one 16-QAM axis.
    // Adjacent levels differ by a single bit: 00,01,11,10 -> -3,-1,+1,+3.
    function automatic logic signed [2:0] gray_level(input logic [1:0] g);
        logic signed [2:0] lvl;
        case (g)
            2'b00:   lvl = -3'sd3;
            2'b01:   lvl = -3'sd1;
            2'b11:   lvl = 3'sd1;
            default: lvl = 3'sd3;
        endcase
        return lvl;
    endfunction

    // QPSK level multiplier for one axis bit: 0 -> -2, 1 -> +2.
    function automatic logic signed [2:0] qpsk_level(input logic b);
        return b ? 3'(c_QPSK_MULT) : -3'(c_QPSK_MULT);
    endfunction

endpackage : qam_pkg

`default_nettype wire

// File: rtl/bit_strobe_det.sv
// ============================================================================
//  Module      : bit_strobe_det
//  Description : Detects the falling edge of the upstream bit_change flag.
//                accept is high in the cycle where bit_change is low and was
//                high in the previous cycle; the new serial bit is valid in
//                that same cycle.
//  Ports       : clock      - system clock (rising edge)
//                reset      - synchronous, active-high reset
//                bit_change - upstream bit-change flag
//                accept     - combinational strobe: take bit_in this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_strobe_det (
    input  logic clock,
    input  logic reset,
    input  logic bit_change,
    output logic accept
);

    // Reset to 0 so a flag that is already low after reset is not mistaken
    // for a falling edge.
    logic r_hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= bit_change;
        end
    end

    assign accept = r_hist & ~bit_change;

endmodule : bit_strobe_det

`default_nettype wire

// File: rtl/qam_symbol_mapper.sv
// ============================================================================
//  Module      : qam_symbol_mapper
//  Description : Collects BITS_PER_SYM serial bits (MSB first) from the
//                upstream generator and maps each complete symbol to signed
//                I/Q amplitudes. 16-QAM uses a Gray-coded 4-level axis
//                (+/-1, +/-3 steps); QPSK uses +/-2 steps per axis.
//  Ports       : clock      - system clock (rising edge)
//                reset      - synchronous, active-high reset
//                enable     - mapper runs while high
//                resync     - discard partial symbol, realign boundary
//                bit_in     - upstream serial data bit
//                bit_change - upstream flag; new bit after its falling edge
//                i_out      - signed in-phase amplitude (registered)
//                q_out      - signed quadrature amplitude (registered)
//                sym_valid  - one-cycle pulse when i_out/q_out update
//                sym_cnt    - emitted symbol count, wraps at 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam_symbol_mapper
    import qam_pkg::*;
#(
    parameter int BITS_PER_SYM = 4,
    parameter int AMP_W        = 8,
    parameter int LEVEL_STEP   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          resync,
    input  logic                          bit_in,
    input  logic                          bit_change,
    output logic signed [AMP_W-1:0]       i_out,
    output logic signed [AMP_W-1:0]       q_out,
    output logic                          sym_valid,
    output logic [c_SYM_CNT_W-1:0]        sym_cnt
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!(BITS_PER_SYM == 2 || BITS_PER_SYM == 4)) begin : g_bad_bps
        $error("qam_symbol_mapper: BITS_PER_SYM must be 2 or 4");
    end

    // The largest level (3 steps) must fit the signed output, which is why
    // the datapath needs no saturation.
    if (3 * LEVEL_STEP > (2 ** (AMP_W - 1)) - 1) begin : g_bad_step
        $error("qam_symbol_mapper: 3*LEVEL_STEP exceeds AMP_W range");
    end

    localparam logic signed [AMP_W+1:0] c_STEP     = (AMP_W + 2)'(LEVEL_STEP);
    localparam logic [2:0]              c_LAST_BIT = 3'(BITS_PER_SYM - 1);

    // ------------------------------------------------------------------
    // Bit strobe
    // ------------------------------------------------------------------
    logic w_accept;

    bit_strobe_det u_bit_strobe_det (
        .clock      (clock),
        .reset      (reset),
        .bit_change (bit_change),
        .accept     (w_accept)
    );

    // ------------------------------------------------------------------
    // Symbol assembly and mapping
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [2:0]              r_bit_cnt;
    // Holds only the bits of a partial symbol; the final bit is merged
    // combinationally, so BITS_PER_SYM-1 bits suffice.
    logic [BITS_PER_SYM-2:0] r_sym_sr;
    logic [c_SYM_CNT_W-1:0]  r_sym_cnt;

    logic [BITS_PER_SYM-1:0] w_sr_next;
    logic signed [2:0]       w_i_lvl;
    logic signed [2:0]       w_q_lvl;
    logic signed [AMP_W+1:0] w_i_mult;
    logic signed [AMP_W+1:0] w_q_mult;

    assign w_sr_next = {r_sym_sr, bit_in};

    if (BITS_PER_SYM == 4) begin : g_qam16
        assign w_i_lvl = gray_level(w_sr_next[3:2]);
        assign w_q_lvl = gray_level(w_sr_next[1:0]);
    end else begin : g_qpsk
        assign w_i_lvl = qpsk_level(w_sr_next[1]);
        assign w_q_lvl = qpsk_level(w_sr_next[0]);
    end

    // Sign-extend the level to the product width.
    assign w_i_mult = {{(AMP_W - 1){w_i_lvl[2]}}, w_i_lvl};
    assign w_q_mult = {{(AMP_W - 1){w_q_lvl[2]}}, w_q_lvl};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_sym_sr  <= '0;
            r_sym_cnt <= '0;
            i_out     <= '0;
            q_out     <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Accepts are ignored here; the first bit after
                    // enabling starts a fresh symbol.
                    r_bit_cnt <= 3'd0;
                    r_sym_sr  <= '0;
                    if (enable) begin
                        r_state <= COLLECT;
                    end
                end
                default: begin
                    if (!enable) begin
                        // Disable wins over a coincident completing accept.
                        r_state   <= IDLE;
                        r_bit_cnt <= 3'd0;
                        r_sym_sr  <= '0;
                    end else if (resync) begin
                        // A coincident bit becomes bit 0 of the new symbol.
                        r_sym_sr  <= (BITS_PER_SYM - 1)'(w_accept & bit_in);
                        r_bit_cnt <= w_accept ? 3'd1 : 3'd0;
                    end else if (w_accept) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= 3'd0;
                            r_sym_sr  <= '0;
                            i_out     <= AMP_W'(w_i_mult * c_STEP);
                            q_out     <= AMP_W'(w_q_mult * c_STEP);
                            sym_valid <= 1'b1;
                            r_sym_cnt <= r_sym_cnt + 16'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_sym_sr  <= w_sr_next[BITS_PER_SYM-2:0];
                        end
                    end
                end
            endcase
        end
    end

    assign sym_cnt = r_sym_cnt;

endmodule : qam_symbol_mapper

`default_nettype wire

// File: tb/tb_qam_symbol_mapper.sv
// ============================================================================
//  Module      : tb_qam_symbol_mapper
//  Description : Directed self-checking bench for qam_symbol_mapper. One
//                16-QAM instance and one QPSK instance, each with its own
//                stimulus signals; expected amplitudes are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qam_symbol_mapper;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // 16-QAM instance signals
    logic              en4 = 1'b0, rs4 = 1'b0, bi4 = 1'b0, bc4 = 1'b0;
    logic signed [7:0] i4, q4;
    logic              v4;
    logic [15:0]       cnt4;

    // QPSK instance signals
    logic              en2 = 1'b0, rs2 = 1'b0, bi2 = 1'b0, bc2 = 1'b0;
    logic signed [7:0] i2, q2;
    logic              v2;
    logic [15:0]       cnt2;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clock = ~clock;

    qam_symbol_mapper #(.BITS_PER_SYM(4), .AMP_W(8), .LEVEL_STEP(32)) dut4 (
        .clock(clock), .reset(reset), .enable(en4), .resync(rs4),
        .bit_in(bi4), .bit_change(bc4),
        .i_out(i4), .q_out(q4), .sym_valid(v4), .sym_cnt(cnt4)
    );

    qam_symbol_mapper #(.BITS_PER_SYM(2), .AMP_W(8), .LEVEL_STEP(32)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .resync(rs2),
        .bit_in(bi2), .bit_change(bc2),
        .i_out(i2), .q_out(q2), .sym_valid(v2), .sym_cnt(cnt2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One upstream bit: raise the flag, then drop it; the accept cycle ends
    // on the second edge, so a completing bit is visible on return.
    task automatic send4(input logic b);
        bi4 = b; bc4 = 1'b1;
        tick();
        bc4 = 1'b0;
        tick();
    endtask

    task automatic send2(input logic b);
        bi2 = b; bc2 = 1'b1;
        tick();
        bc2 = 1'b0;
        tick();
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_i", i4, 0);
        chk("rst_q", q4, 0);
        chk("rst_valid", v4, 0);
        chk("rst_cnt", cnt4, 0);

        // ---------------- 16-QAM: 0110 then 1100 ----------------
        en4 = 1'b1;
        tick();
        send4(0); send4(1); send4(1);
        chk("s1_no_early_valid", v4, 0);
        send4(0);
        chk("s1_valid", v4, 1);
        chk("s1_i", i4, -32);
        chk("s1_q", q4, 96);
        tick();
        chk("s1_valid_one_cycle", v4, 0);
        chk("s1_i_hold", i4, -32);
        send4(1); send4(1); send4(0); send4(0);
        chk("s2_valid", v4, 1);
        chk("s2_i", i4, 32);
        chk("s2_q", q4, -96);
        chk("s2_cnt", cnt4, 2);

        // ---------------- partial symbol dropped by enable ----------------
        send4(1); send4(1);
        en4 = 1'b0;
        tick();
        en4 = 1'b1;
        tick();
        chk("drop_i_hold", i4, 32);
        chk("drop_cnt_hold", cnt4, 2);
        send4(0); send4(0); send4(0); send4(0);
        chk("drop_valid", v4, 1);
        chk("drop_i", i4, -96);
        chk("drop_q", q4, -96);
        chk("drop_cnt", cnt4, 3);

        // ---------------- resync coincident with accept ----------------
        send4(0); send4(0);          // junk partial, discarded by resync
        bi4 = 1'b1; bc4 = 1'b1;
        tick();
        bc4 = 1'b0; rs4 = 1'b1;
        tick();
        rs4 = 1'b0;
        send4(0); send4(1);
        chk("rsy_no_early_valid", v4, 0);
        send4(1);
        chk("rsy_valid", v4, 1);
        chk("rsy_i", i4, 96);
        chk("rsy_q", q4, 32);
        chk("rsy_cnt", cnt4, 4);

        // ---------------- flag held high: no accepts ----------------
        pulses = 0;
        bc4 = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            bi4 = k[0];
            tick();
            if (v4) pulses++;
        end
        chk("hold_pulses", pulses, 0);
        chk("hold_i", i4, 96);
        chk("hold_q", q4, 32);
        chk("hold_cnt", cnt4, 4);

        // ---------------- counter wrap ----------------
        force dut4.r_sym_cnt = 16'hFFFF;
        #1;
        release dut4.r_sym_cnt;
        chk("wrap_preload", cnt4, 65535);
        send4(1); send4(0); send4(1); send4(0);
        chk("wrap_valid", v4, 1);
        chk("wrap_cnt", cnt4, 0);
        chk("wrap_i", i4, 96);
        chk("wrap_q", q4, 96);

        // ---------------- disable coincident with completing accept --------
        tick();
        send4(1); send4(1); send4(1);
        bi4 = 1'b1; bc4 = 1'b1;
        tick();
        bc4 = 1'b0; en4 = 1'b0;
        tick();
        chk("dis_no_valid", v4, 0);
        chk("dis_cnt", cnt4, 0);
        chk("dis_i_hold", i4, 96);
        en4 = 1'b1;
        tick();

        // ---------------- reset mid-symbol ----------------
        send4(1); send4(1);
        reset = 1'b1;
        tick();
        chk("mrst_valid", v4, 0);
        chk("mrst_cnt", cnt4, 0);
        chk("mrst_i", i4, 0);
        chk("mrst_q", q4, 0);
        reset = 1'b0;
        tick();
        tick();
        // Partial bits before reset must not contribute.
        send4(1); send4(1); send4(1); send4(1);
        chk("mrst_sym_i", i4, 32);
        chk("mrst_sym_q", q4, 32);
        chk("mrst_sym_cnt", cnt4, 1);

        // ---------------- QPSK: bits 1,0,0,1 ----------------
        en2 = 1'b1;
        tick();
        send2(1);
        chk("qp1_no_early_valid", v2, 0);
        send2(0);
        chk("qp1_valid", v2, 1);
        chk("qp1_i", i2, 64);
        chk("qp1_q", q2, -64);
        tick();
        chk("qp1_valid_one_cycle", v2, 0);
        send2(0); send2(1);
        chk("qp2_valid", v2, 1);
        chk("qp2_i", i2, -64);
        chk("qp2_q", q2, 64);
        chk("qp2_cnt", cnt2, 2);
        tick();
        chk("qp2_valid_one_cycle", v2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_qam_symbol_mapper

`default_nettype wire
